s_divider: RTL and testbench

S_DIVIDER -- requirements
Module: s_divider

---
 rtl/s_divider.sv | 118 +++++++++++
 tb/tb_s_divider.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/s_divider.sv
// Iterative signed/unsigned divider: one quotient bit per clock by restoring
// shift-subtract on N-bit magnitudes, with the sign fix applied on entry to DONE.
module s_divider #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  output logic         rdy_o,
  input  logic [2:0]   mdu_op_i,
  input  logic [N:0]   ai,
  input  logic [N:0]   bi,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  input  logic         rem_op_i,
  input  logic         a_is_zero_i,
  input  logic         b_is_zero_i
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_rem, r_quo, r_div, r_a_lo;
  logic [N-1:0]   r_q_out, r_r_out;
  logic           r_sgn_q, r_sgn_r, r_a_zero, r_b_zero;

  logic           w_accept, w_finish;
  logic           w_a_neg, w_b_neg;
  logic [N-1:0]   w_a_mag, w_b_mag;
  logic [N:0]     w_shift;
  logic [N+1:0]   w_diff;
  logic           w_qbit;
  logic [N-1:0]   w_rem_nxt;
  logic           w_unused;

  // A new request is taken in IDLE and also on the edge leaving DONE.
  assign w_accept = req_i && (r_state == IDLE || r_state == DONE);
  assign w_finish = r_a_zero || r_b_zero || (r_cnt == CW'(N));

  assign w_a_neg = ~mdu_op_i[0] & ai[N];
  assign w_b_neg = ~mdu_op_i[0] & bi[N];
  assign w_a_mag = w_a_neg ? -ai[N-1:0] : ai[N-1:0];
  assign w_b_mag = w_b_neg ? -bi[N-1:0] : bi[N-1:0];

  // Restoring step: dividend bits shift out of r_quo into the partial remainder.
  assign w_shift   = {r_rem, r_quo[N-1]};
  assign w_diff    = {1'b0, w_shift} - {2'b0, r_div};
  assign w_qbit    = ~w_diff[N+1];
  assign w_rem_nxt = w_qbit ? w_diff[N-1:0] : w_shift[N-1:0];

  // The remainder after a successful subtract is below the divisor, so w_diff[N] is always 0 then.
  assign w_unused = ^{rem_op_i, mdu_op_i[2:1], w_diff[N]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (w_finish) w_next = DONE;
      DONE:    w_next = w_accept ? CALC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_a_lo   <= '0;
      r_q_out  <= '0;
      r_r_out  <= '0;
      r_sgn_q  <= 1'b0;
      r_sgn_r  <= 1'b0;
      r_a_zero <= 1'b0;
      r_b_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= w_a_mag;
      r_div    <= w_b_mag;
      r_a_lo   <= ai[N-1:0];
      r_sgn_q  <= w_a_neg ^ w_b_neg;
      r_sgn_r  <= w_a_neg;
      r_a_zero <= a_is_zero_i;
      r_b_zero <= b_is_zero_i;
    end else if (r_state == CALC) begin
      // Zero operands bypass the iterations and finish on the first CALC edge.
      if (r_b_zero) begin
        r_q_out <= '1;
        r_r_out <= r_a_lo;
      end else if (r_a_zero) begin
        r_q_out <= '0;
        r_r_out <= '0;
      end else if (r_cnt == CW'(N)) begin
        r_q_out <= r_sgn_q ? -r_quo : r_quo;
        r_r_out <= r_sgn_r ? -r_rem : r_rem;
      end else begin
        r_rem <= w_rem_nxt;
        r_quo <= {r_quo[N-2:0], w_qbit};
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign rdy_o       = (r_state == DONE);
  assign quotient_o  = r_q_out;
  assign remainder_o = r_r_out;

endmodule

// File: tb/tb_s_divider.sv
// Bench for s_divider: arithmetic reference model with a per-cycle compare,
// plus directed vectors carrying hand-computed results and latencies.
module tb_s_divider;
  localparam int N = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_i = 1'b0;
  logic          rdy_o;
  logic [2:0]    mdu_op_i = 3'd4;
  logic [N:0]    ai = '0;
  logic [N:0]    bi = '0;
  logic [N-1:0]  quotient_o, remainder_o;
  logic          rem_op_i = 1'b0;
  logic          a_is_zero_i = 1'b0;
  logic          b_is_zero_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  s_divider #(.N(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .rdy_o(rdy_o),
    .mdu_op_i(mdu_op_i), .ai(ai), .bi(bi),
    .quotient_o(quotient_o), .remainder_o(remainder_o),
    .rem_op_i(rem_op_i), .a_is_zero_i(a_is_zero_i), .b_is_zero_i(b_is_zero_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Results straight from the arithmetic rules: zero flags first, then C-style truncating division.
  function automatic logic [63:0] ref_div(input logic [2:0] op, input logic [32:0] a,
                                          input logic [32:0] b, input logic az, input logic bz);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     q, r;
    if (bz) return {32'hFFFF_FFFF, a[31:0]};
    if (az) return 64'd0;
    if (op[0]) begin
      ua = {32'b0, a[31:0]};
      ub = {32'b0, b[31:0]};
      q  = ua / ub;
      r  = ua % ub;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
    end
    return {q[31:0], r[31:0]};
  endfunction

  // Transaction-level model: busy countdown plus the results it will publish.
  logic        m_busy = 1'b0;
  logic        m_rdy  = 1'b0;
  int          m_left = 0;
  logic [31:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;
  logic [63:0] m_e;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_busy <= 1'b0; m_rdy <= 1'b0; m_left <= 0;
      m_q <= '0; m_r <= '0; m_pq <= '0; m_pr <= '0;
    end else begin
      m_rdy <= 1'b0;
      if (!m_busy && req_i) begin
        m_e    = ref_div(mdu_op_i, ai, bi, a_is_zero_i, b_is_zero_i);
        m_pq   <= m_e[63:32];
        m_pr   <= m_e[31:0];
        m_busy <= 1'b1;
        m_left <= (a_is_zero_i || b_is_zero_i) ? 1 : N + 1;
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_rdy  <= 1'b1;
          m_q    <= m_pq;
          m_r    <= m_pr;
        end
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    chk("cmp rdy",  32'(rdy_o), 32'(m_rdy));
    chk("cmp quot", quotient_o, m_q);
    chk("cmp rem",  remainder_o, m_r);
  end

  task automatic drive(input logic [2:0] op, input logic [32:0] a, input logic [32:0] b);
    mdu_op_i    = op;
    ai          = a;
    bi          = b;
    a_is_zero_i = (a[31:0] == 32'd0);
    b_is_zero_i = (b[31:0] == 32'd0);
    rem_op_i    = op[1];
  endtask

  task automatic wait_rdy(output int k);
    k = 0;
    do begin
      @(posedge clk_i); #1;
      k++;
    end while (!rdy_o && k < 100);
    chk("rdy seen", 32'(rdy_o), 32'd1);
  endtask

  // Called at a falling edge; returns at a falling edge during the DONE cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [32:0] a,
                        input logic [32:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input int elat);
    int k;
    drive(op, a, b);
    req_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    // Junk on the inputs while busy must not disturb the result.
    drive(3'd7, 33'h1_2345_6789, 33'h0_0000_0000);
    wait_rdy(k);
    chk({name, " latency"}, 32'(k), 32'(elat));
    chk({name, " quot"}, quotient_o, eq);
    chk({name, " rem"},  remainder_o, er);
    @(negedge clk_i);
  endtask

  logic [2:0]  bop[4];
  logic [32:0] ba[4], bbv[4];

  initial begin
    int k, last;
    logic [63:0] e;
    rst_i = 1'b1;
    #1;
    chk("reset rdy",  32'(rdy_o), 32'd0);
    chk("reset quot", quotient_o, 32'd0);
    chk("reset rem",  remainder_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op("rem s",      3'd6, 33'h1_FFFF_3380, 33'h1_FFFF_FFCC, 32'd1006,      32'hFFFF_FFD8, N + 1);
    run_op("divu",       3'd5, 33'h0_FFFF_FFFF, 33'h0_0000_0002, 32'h7FFF_FFFF, 32'd1,         N + 1);
    run_op("div by 0",   3'd4, 33'h0_0000_0007, 33'h0_0000_0000, 32'hFFFF_FFFF, 32'd7,         1);
    run_op("overflow",   3'd4, 33'h1_8000_0000, 33'h1_FFFF_FFFF, 32'h8000_0000, 32'd0,         N + 1);
    run_op("a zero",     3'd7, 33'h0_0000_0000, 33'h0_0000_0005, 32'd0,         32'd0,         1);
    run_op("100/-7",     3'd4, 33'h0_0000_0064, 33'h1_FFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         N + 1);
    run_op("-100/7",     3'd6, 33'h1_FFFF_FF9C, 33'h0_0000_0007, 32'hFFFF_FFF2, 32'hFFFF_FFFE, N + 1);
    run_op("divu msb",   3'd5, 33'h0_8000_0000, 33'h0_0000_0003, 32'h2AAA_AAAA, 32'd2,         N + 1);
    run_op("neg by 0",   3'd4, 33'h1_FFFF_FFF9, 33'h0_0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);
    run_op("0 by 0",     3'd4, 33'h0_0000_0000, 33'h0_0000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("small/big",  3'd5, 33'h0_0000_0005, 33'h0_0000_0009, 32'd0,         32'd5,         N + 1);

    // Abort during CALC: outputs clear at once and the aborted op never completes.
    drive(3'd5, 33'h0_0000_03E8, 33'h0_0000_0003);
    req_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("abort rdy",  32'(rdy_o), 32'd0);
    chk("abort quot", quotient_o, 32'd0);
    chk("abort rem",  remainder_o, 32'd0);
    @(negedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_op("after abort", 3'd5, 33'h0_0000_03E8, 33'h0_0000_0003, 32'd333, 32'd1, N + 1);

    // Back-to-back with req_i held high.
    bop[0] = 3'd4; ba[0] = 33'h0_0000_0064; bbv[0] = 33'h1_FFFF_FFF9;
    bop[1] = 3'd6; ba[1] = 33'h1_FFFF_FF9C; bbv[1] = 33'h0_0000_0007;
    bop[2] = 3'd5; ba[2] = 33'h0_DEAD_BEEF; bbv[2] = 33'h0_0000_1234;
    bop[3] = 3'd7; ba[3] = 33'h0_1234_5678; bbv[3] = 33'h1_FFFF_FF00;
    drive(bop[0], ba[0], bbv[0]);
    req_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    drive(bop[1], ba[1], bbv[1]);
    last = 0;
    for (int i = 0; i < 4; i++) begin
      wait_rdy(k);
      if (i > 0) chk("b2b period", 32'(cyc - last), 32'(N + 2));
      last = cyc;
      e = ref_div(bop[i], ba[i], bbv[i], ba[i][31:0] == 32'd0, bbv[i][31:0] == 32'd0);
      chk("b2b quot", quotient_o, e[63:32]);
      chk("b2b rem",  remainder_o, e[31:0]);
      if (i == 0) begin
        chk("b2b 100/-7 quot", quotient_o, 32'hFFFF_FFF2);
        chk("b2b 100/-7 rem",  remainder_o, 32'd2);
      end
      if (i < 3) begin
        @(posedge clk_i);
        @(negedge clk_i);
        if (i + 2 < 4) drive(bop[i+2], ba[i+2], bbv[i+2]);
        else req_i = 1'b0;
      end
    end
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (3) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
